// File: rtl/uart_reg_responder.sv
// Serial register-access responder: drains 5-byte command frames from a UART RX FIFO and answers via the TX FIFO.
// Optional inter-byte timeout is built only when UART_RESP_TIMEOUT_EN is defined.
module uart_reg_responder #(
    parameter int         NUM_REGS       = 4,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         POP_GAP        = 2,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_empty,
    input  logic                  tx_full,
    output logic                  pulse_rx,
    output logic                  pulse_tx,
    output logic [7:0]            tx_data,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic [7:0]            frame_cnt,
    output logic                  err_chk,
    output logic                  err_timeout
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int GW = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    // HUNT: wait sync byte | POP: pop pulse | GAP: settle, act on byte | STORE: wait frame byte
    // EXEC: check and execute | TX_LOAD: wait room | TX_PULSE: push pulse | TX_GAP: settle after push
    typedef enum logic [2:0] {HUNT, POP, GAP, STORE, EXEC, TX_LOAD, TX_PULSE, TX_GAP} state_t;

    state_t                state, state_nxt;
    logic [2:0]            idx;
    logic [7:0]            cap, cmd, addr, data, chk, rd_byte;
    logic [GW-1:0]         gap_cnt;
    logic                  second_pending;
    logic [NUM_REGS*8-1:0] reg_bank;
    logic                  frame_ok;
    logic                  tmo_hit;

    assign frame_ok = ((cmd ^ addr ^ data) == chk) && ((cmd == CMD_W) || (cmd == CMD_R))
                      && ({1'b0, addr} < 9'(NUM_REGS));

    assign pulse_rx = (state == POP);
    assign pulse_tx = (state == TX_PULSE);
    assign err_chk  = (state == EXEC) && !frame_ok;
    assign reg_out  = reg_bank;

`ifdef UART_RESP_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_cnt <= 32'(TIMEOUT_CYCLES - 1);
        end else if (state == POP) begin
            tmo_cnt <= 32'(TIMEOUT_CYCLES - 1);
        end else if ((state == STORE) && rx_empty && (tmo_cnt != 32'd0)) begin
            tmo_cnt <= tmo_cnt - 32'd1;
        end
    end

    assign tmo_hit     = (state == STORE) && rx_empty && (tmo_cnt == 32'd0);
    assign err_timeout = tmo_hit;
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT, STORE: begin
                if (tmo_hit)        state_nxt = HUNT;
                else if (!rx_empty) state_nxt = POP;
            end
            POP:      state_nxt = GAP;
            GAP: begin
                if (gap_cnt == '0) begin
                    if (idx == 3'd0)      state_nxt = (cap == SYNC_BYTE) ? STORE : HUNT;
                    else if (idx == 3'd4) state_nxt = EXEC;
                    else                  state_nxt = STORE;
                end
            end
            EXEC:     state_nxt = TX_LOAD;
            TX_LOAD:  if (!tx_full) state_nxt = TX_PULSE;
            TX_PULSE: state_nxt = TX_GAP;
            TX_GAP: begin
                if (gap_cnt == '0) state_nxt = second_pending ? TX_LOAD : HUNT;
            end
            default:  state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= HUNT;
            idx            <= 3'd0;
            cap            <= 8'h00;
            cmd            <= 8'h00;
            addr           <= 8'h00;
            data           <= 8'h00;
            chk            <= 8'h00;
            rd_byte        <= 8'h00;
            gap_cnt        <= '0;
            second_pending <= 1'b0;
            reg_bank       <= '0;
            tx_data        <= 8'h00;
            frame_cnt      <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                HUNT, STORE: begin
                    if (tmo_hit)        idx <= 3'd0;
                    else if (!rx_empty) cap <= rx_data;
                end
                POP:      gap_cnt <= GW'(POP_GAP - 1);
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else begin
                        case (idx)
                            3'd0: if (cap == SYNC_BYTE) idx <= 3'd1;
                            3'd1: begin cmd  <= cap; idx <= 3'd2; end
                            3'd2: begin addr <= cap; idx <= 3'd3; end
                            3'd3: begin data <= cap; idx <= 3'd4; end
                            default: chk <= cap;
                        endcase
                    end
                end
                EXEC: begin
                    if (frame_ok) begin
                        frame_cnt      <= frame_cnt + 8'd1;
                        tx_data        <= ACK;
                        second_pending <= (cmd == CMD_R);
                        rd_byte        <= reg_bank[{addr[AW-1:0], 3'b000} +: 8];
                        if (cmd == CMD_W) reg_bank[{addr[AW-1:0], 3'b000} +: 8] <= data;
                    end else begin
                        tx_data        <= NAK;
                        second_pending <= 1'b0;
                    end
                end
                TX_PULSE: gap_cnt <= GW'(POP_GAP - 1);
                TX_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (second_pending) begin
                        // read data follows the ACK as a second pushed byte
                        tx_data        <= rd_byte;
                        second_pending <= 1'b0;
                    end else begin
                        idx <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder: FIFO models around the DUT, a frame-level reference model,
// table vectors, hand-written corner sequences and randomized back-to-back frames.
module tb_uart_reg_responder;
    localparam int NREG = 4;
    localparam int GAPC = 2;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_empty = 1'b1;
    logic            tx_full = 1'b0;
    logic            pulse_rx, pulse_tx, err_chk, err_timeout;
    logic [7:0]      tx_data, frame_cnt;
    logic [NREG*8-1:0] reg_out;

    always #5 clk = ~clk;

    uart_reg_responder #(
        .NUM_REGS(NREG), .SYNC_BYTE(8'hA5), .POP_GAP(GAPC), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_empty(rx_empty), .tx_full(tx_full),
        .pulse_rx(pulse_rx), .pulse_tx(pulse_tx), .tx_data(tx_data), .reg_out(reg_out),
        .frame_cnt(frame_cnt), .err_chk(err_chk), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad = 0;

    logic [7:0] rx_q[$];
    logic [7:0] got_tx[$];
    logic [7:0] exp_tx[$];

    logic [7:0] m_reg[NREG];
    logic [7:0] m_frm[5];
    int         m_cnt = 0;
    int         m_err = 0;
    int         m_pos = 0;

    int   err_seen = 0;
    int   tmo_seen = 0;
    int   pop_cnt = 0;
    int   viol = 0;
    int   since = 100;
    logic prev_err = 1'b0;
    bit   bp_rand = 1'b0;
    bit   full_force = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO models and protocol monitor; all activity away from the rising edge
    always @(negedge clk) begin
        if (nrst) begin
            since++;
            if (pulse_rx || pulse_tx) begin
                if (since < GAPC + 2) viol++;
                since = 0;
            end
            if (pulse_rx && pulse_tx) viol++;
            if (err_chk && prev_err) viol++;
            if (pulse_rx && rx_q.size() == 0) viol++;
            if (pulse_tx && tx_full) viol++;
            prev_err = err_chk;
            if (err_chk) err_seen++;
            if (err_timeout) tmo_seen++;
            if (pulse_rx && rx_q.size() != 0) begin
                void'(rx_q.pop_front());
                pop_cnt++;
            end
            if (pulse_tx) got_tx.push_back(tx_data);
        end
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
        tx_full  = bp_rand ? ($urandom_range(0, 2) == 0) : full_force;
    end

    // Reference model: frame-level parse of the byte stream
    task automatic m_exec();
        logic [7:0] c, a, d, k;
        c = m_frm[1]; a = m_frm[2]; d = m_frm[3]; k = m_frm[4];
        if (((c ^ a ^ d) != k) || !((c == 8'h57) || (c == 8'h52)) || (int'(a) >= NREG)) begin
            exp_tx.push_back(8'h15);
            m_err++;
        end else begin
            m_cnt = (m_cnt + 1) % 256;
            exp_tx.push_back(8'h06);
            if (c == 8'h57) m_reg[a] = d;
            else            exp_tx.push_back(m_reg[a]);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_q.push_back(b);
        if (m_pos == 0) begin
            if (b == 8'hA5) m_pos = 1;
        end else begin
            m_frm[m_pos] = b;
            m_pos++;
            if (m_pos == 5) begin
                m_exec();
                m_pos = 0;
            end
        end
    endtask

    function automatic logic [NREG*8-1:0] m_bank();
        logic [NREG*8-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*8 +: 8] = m_reg[i];
        return v;
    endfunction

    task automatic settle(input int budget);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || got_tx.size() < exp_tx.size()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic check_batch(input string tag);
        check({tag, " tx_count"}, 64'(got_tx.size()), 64'(exp_tx.size()));
        for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
            check($sformatf("%s tx_byte%0d", tag, i), 64'(got_tx[i]), 64'(exp_tx[i]));
        check({tag, " frame_cnt"}, 64'(frame_cnt), 64'(m_cnt));
        check({tag, " reg_out"}, 64'(reg_out), 64'(m_bank()));
        check({tag, " err_pulses"}, 64'(err_seen), 64'(m_err));
        got_tx.delete();
        exp_tx.delete();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_reg[i] = 8'h00;
        m_cnt = 0; m_err = 0; m_pos = 0; err_seen = 0;
        rx_q.delete(); got_tx.delete(); exp_tx.delete();
    endtask

    typedef struct {
        logic [7:0] b[5];
        int         n;
        logic [7:0] r0;
        logic [7:0] r1;
    } vec_t;

    vec_t vt[6];

    initial begin
        int pops0, pushes0, changes, tmo0, junk;
        logic [7:0] td, c, a, d, k;

        vt[0] = '{b: '{8'hA5, 8'h57, 8'h02, 8'h3C, 8'h69}, n: 1, r0: 8'h06, r1: 8'h00};
        vt[1] = '{b: '{8'hA5, 8'h52, 8'h02, 8'h00, 8'h50}, n: 2, r0: 8'h06, r1: 8'h3C};
        vt[2] = '{b: '{8'hA5, 8'h57, 8'h01, 8'h11, 8'h00}, n: 1, r0: 8'h15, r1: 8'h00};
        vt[3] = '{b: '{8'hA5, 8'h57, 8'h07, 8'h11, 8'h40}, n: 1, r0: 8'h15, r1: 8'h00};
        vt[4] = '{b: '{8'hA5, 8'h41, 8'h00, 8'h00, 8'h41}, n: 1, r0: 8'h15, r1: 8'h00};
        vt[5] = '{b: '{8'hA5, 8'h52, 8'h03, 8'h00, 8'h51}, n: 2, r0: 8'h06, r1: 8'h00};

        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst pulse_rx", 64'(pulse_rx), 0);
        check("rst pulse_tx", 64'(pulse_tx), 0);
        check("rst tx_data", 64'(tx_data), 0);
        check("rst reg_out", 64'(reg_out), 0);
        check("rst frame_cnt", 64'(frame_cnt), 0);
        @(negedge clk);
        nrst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < 5; j++) send(vt[v].b[j]);
            settle(400);
            check($sformatf("vec%0d tx_count", v), 64'(got_tx.size()), 64'(vt[v].n));
            if (got_tx.size() > 0) check($sformatf("vec%0d tx0", v), 64'(got_tx[0]), 64'(vt[v].r0));
            if (got_tx.size() > 1) check($sformatf("vec%0d tx1", v), 64'(got_tx[1]), 64'(vt[v].r1));
            check_batch($sformatf("vec%0d", v));
            if (v == 0) begin
                check("write reg2", 64'(reg_out[23:16]), 64'h3C);
                check("write frame_cnt", 64'(frame_cnt), 1);
            end
            if (v == 2) check("badchk reg1", 64'(reg_out[15:8]), 0);
        end
        check("table frame_cnt", 64'(frame_cnt), 3);

        // junk bytes ahead of a valid frame are popped silently
        pops0 = pop_cnt;
        send(8'h00); send(8'hFF); send(8'h12);
        send(8'hA5); send(8'h57); send(8'h00); send(8'hAA); send(8'hFD);
        settle(600);
        check("resync pops", 64'(pop_cnt - pops0), 8);
        check("resync reg0", 64'(reg_out[7:0]), 64'hAA);
        check_batch("resync");

        // backpressure: response held off while the TX FIFO is full
        full_force = 1'b1;
        send(8'hA5); send(8'h57); send(8'h03); send(8'h5A); send(8'h0E);
        settle(300);
        td = tx_data;
        pushes0 = got_tx.size();
        changes = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_data != td) changes++;
        end
        check("bp pushes while full", 64'(got_tx.size() - pushes0), 0);
        check("bp tx_data stable", 64'(changes), 0);
        check("bp tx_data value", 64'(td), 64'h06);
        full_force = 1'b0;
        settle(300);
        check_batch("bp release");

        // reset mid-frame clears everything, then a full frame works
        send(8'hA5); send(8'h57);
        settle(200);
        nrst = 1'b0;
        #1;
        check("midrst pulse_rx", 64'(pulse_rx), 0);
        check("midrst pulse_tx", 64'(pulse_tx), 0);
        check("midrst tx_data", 64'(tx_data), 0);
        check("midrst reg_out", 64'(reg_out), 0);
        check("midrst frame_cnt", 64'(frame_cnt), 0);
        check("midrst err_chk", 64'(err_chk), 0);
        check("midrst err_timeout", 64'(err_timeout), 0);
        model_reset();
        repeat (3) @(negedge clk);
        since = 100;
        prev_err = 1'b0;
        nrst = 1'b1;
        send(8'hA5); send(8'h57); send(8'h01); send(8'h77); send(8'h21);
        settle(300);
        check_batch("after reset");

        // stalled partial frame
        tmo0 = tmo_seen;
        send(8'hA5); send(8'h57);
        settle(200);
        repeat (150) @(negedge clk);
`ifdef UART_RESP_TIMEOUT_EN
        check("timeout pulses", 64'(tmo_seen - tmo0), 1);
        check("timeout no tx", 64'(got_tx.size()), 0);
        m_pos = 0;
        send(8'hA5); send(8'h57); send(8'h02); send(8'h3C); send(8'h69);
`else
        check("no timeout pulses", 64'(tmo_seen - tmo0), 0);
        check("stall no tx", 64'(got_tx.size()), 0);
        send(8'h02); send(8'h3C); send(8'h69);
`endif
        settle(400);
        check_batch("stall resume");

        // randomized back-to-back frames, with random backpressure on odd batches
        for (int batch = 0; batch < 4; batch++) begin
            bp_rand = (batch % 2) == 1;
            for (int f = 0; f < 8; f++) begin
                if ($urandom_range(0, 3) == 0) begin
                    junk = $urandom_range(0, 255);
                    send((junk == 8'hA5) ? 8'h00 : 8'(junk));
                end
                junk = $urandom_range(0, 9);
                c = (junk < 4) ? 8'h57 : (junk < 8) ? 8'h52 : 8'($urandom_range(0, 255));
                a = 8'($urandom_range(0, 5));
                d = 8'($urandom_range(0, 255));
                k = ($urandom_range(0, 4) != 0) ? (c ^ a ^ d) : 8'($urandom_range(0, 255));
                send(8'hA5); send(c); send(a); send(d); send(k);
            end
            settle(4000);
            check_batch($sformatf("rand%0d", batch));
        end
        bp_rand = 1'b0;

        check("protocol violations", 64'(viol), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
